// File: rtl/turfio_cin_align_ctrl.sv
// turfio_cin_align_ctrl
// ---------------------
// Automatic training controller for the CIN parallel sync stage (aclk domain).
// After one start pulse it resets the bitslip and lock logic, waits for the
// data to settle, and checks a window of strobes for bit errors. It then
// captures a word and searches all eight nibble rotations of the training
// word. If nothing matches it slips and tries again, up to MAX_SLIPS times.
// Once a match is found it enables lock and waits for locked_i.
//
// Optional feature: define CIN_ALIGN_RELOCK_EN to retrain automatically when
// locked_i drops while in DONE. Without it, losing lock returns the block to IDLE.
//
// Ports
//   aclk_i, aclk_rst_i   CIN clock, async active-high reset
//   start_i              begin alignment (honoured in IDLE/DONE/FAIL only)
//   cin_valid_i          data-valid strobe shared with the sync stage
//   cin_biterr_i         bit-error flag from the sync stage
//   cin_parallel_i[31:0] captured word from the sync stage
//   locked_i             lock flag from the sync stage
//   bitslip_o, bitslip_rst_o, capture_o, lock_rst_o, lock_o
//                        single-cycle registered controls to the sync stage
//   busy_o, done_o, fail_o
//                        run status
//   fail_code_o[1:0]     0 none, 1 bit error, 2 no match, 3 lock timeout
//   slip_count_o[2:0]    slips issued this run (saturates at 7)
//   rotation_o[2:0]      nibble rotation of the matching word
module turfio_cin_align_ctrl #(
    parameter logic [31:0] TRAIN_SEQUENCE = 32'hA55A6996,
    parameter int          SETTLE_CYCLES  = 16,
    parameter int          ERR_WINDOW     = 64,
    parameter int          MAX_SLIPS      = 4,
    parameter int          LOCK_TIMEOUT   = 32
) (
    input  logic        aclk_i,
    input  logic        aclk_rst_i,
    input  logic        start_i,
    input  logic        cin_valid_i,
    input  logic        cin_biterr_i,
    input  logic [31:0] cin_parallel_i,
    input  logic        locked_i,
    output logic        bitslip_o,
    output logic        bitslip_rst_o,
    output logic        capture_o,
    output logic        lock_rst_o,
    output logic        lock_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        fail_o,
    output logic [1:0]  fail_code_o,
    output logic [2:0]  slip_count_o,
    output logic [2:0]  rotation_o
);

    typedef enum logic [3:0] {
        S_IDLE, S_RST, S_SETTLE, S_CHECK, S_CAP, S_CMP, S_SLIP, S_LOCK, S_DONE, S_FAIL
    } state_t;

    state_t      state, state_next;
    logic [15:0] strobe_cnt;
    logic        settle_end, check_end, lock_end;
    logic        match_hit;
    logic [2:0]  match_k;
    logic        bitslip_d, rst_d, capture_d, lock_d;

    // Left-rotate by 4*k bits: the upper half of the doubled word shifted left.
    function automatic logic [31:0] rotl_nib(input logic [31:0] w, input logic [2:0] k);
        logic [63:0] dbl;
        dbl = {w, w} << {k, 2'b00};
        return dbl[63:32];
    endfunction

    // A wait of N strobes ends on the strobe seen while the counter reads N-1.
    assign settle_end = cin_valid_i && (strobe_cnt == 16'(SETTLE_CYCLES - 1));
    assign check_end  = cin_valid_i && (strobe_cnt == 16'(ERR_WINDOW - 1));
    assign lock_end   = cin_valid_i && (strobe_cnt == 16'(LOCK_TIMEOUT - 1));

    // Descending scan so the lowest matching rotation is the one reported.
    always_comb begin
        match_hit = 1'b0;
        match_k   = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            if (cin_parallel_i == rotl_nib(TRAIN_SEQUENCE, 3'(k))) begin
                match_hit = 1'b1;
                match_k   = 3'(k);
            end
        end
    end

    // State register and registered pulse outputs
    always_ff @(posedge aclk_i or posedge aclk_rst_i) begin
        if (aclk_rst_i) begin
            state         <= S_IDLE;
            bitslip_o     <= 1'b0;
            bitslip_rst_o <= 1'b0;
            lock_rst_o    <= 1'b0;
            capture_o     <= 1'b0;
            lock_o        <= 1'b0;
        end else begin
            state         <= state_next;
            bitslip_o     <= bitslip_d;
            bitslip_rst_o <= rst_d;
            lock_rst_o    <= rst_d;
            capture_o     <= capture_d;
            lock_o        <= lock_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE:   if (start_i) state_next = S_RST;
            S_RST:    state_next = S_SETTLE;
            S_SETTLE: if (settle_end) state_next = S_CHECK;
            S_CHECK: begin
                if (cin_biterr_i)   state_next = S_FAIL;
                else if (check_end) state_next = S_CAP;
            end
            S_CAP:    state_next = S_CMP;
            S_CMP: begin
                if (match_hit)                        state_next = S_LOCK;
                else if (slip_count_o >= 3'(MAX_SLIPS)) state_next = S_FAIL;
                else                                  state_next = S_SLIP;
            end
            S_SLIP:   state_next = S_SETTLE;
            // locked_i is tested first so a lock on the final strobe still succeeds.
            S_LOCK: begin
                if (locked_i)      state_next = S_DONE;
                else if (lock_end) state_next = S_FAIL;
            end
            S_DONE: begin
                if (start_i) begin
                    state_next = S_RST;
                end else if (!locked_i) begin
`ifdef CIN_ALIGN_RELOCK_EN
                    state_next = S_RST;
`else
                    state_next = S_IDLE;
`endif
                end
            end
            S_FAIL:   if (start_i) state_next = S_RST;
            default:  state_next = S_IDLE;
        endcase
    end

    // Output decode: pulses are decoded from the next state so the registered
    // copy lines up with the state it belongs to.
    always_comb begin
        bitslip_d = (state_next == S_SLIP);
        rst_d     = (state_next == S_RST);
        capture_d = (state_next == S_CAP);
        lock_d    = (state_next == S_LOCK) && (state != S_LOCK);
        busy_o    = !((state == S_IDLE) || (state == S_DONE) || (state == S_FAIL));
        done_o    = (state == S_DONE);
        fail_o    = (state == S_FAIL);
    end

    // Strobe counter and run results
    always_ff @(posedge aclk_i or posedge aclk_rst_i) begin
        if (aclk_rst_i) begin
            strobe_cnt   <= '0;
            slip_count_o <= '0;
            rotation_o   <= '0;
            fail_code_o  <= '0;
        end else begin
            if (state_next != state)
                strobe_cnt <= '0;
            else if (cin_valid_i)
                strobe_cnt <= strobe_cnt + 16'd1;

            // RST is only entered at the start of a run (including relock).
            if (state_next == S_RST) begin
                slip_count_o <= '0;
                rotation_o   <= '0;
                fail_code_o  <= '0;
            end else begin
                if (state == S_SLIP && slip_count_o != 3'd7)
                    slip_count_o <= slip_count_o + 3'd1;
                if (state == S_CMP && match_hit)
                    rotation_o <= match_k;
                if (state_next == S_FAIL && state != S_FAIL) begin
                    unique case (state)
                        S_CHECK: fail_code_o <= 2'd1;
                        S_CMP:   fail_code_o <= 2'd2;
                        default: fail_code_o <= 2'd3;
                    endcase
                end
            end
        end
    end

endmodule
